// File: rtl/vote_collector.sv
// Ballot-capture stage: debounces four voter buttons, runs a timed session on start,
// and holds the frozen one-vote-per-voter ballot for the downstream combinational voter.
module vote_collector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int VOTE_WINDOW     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] btn,
    output logic [3:0] ballot,
    output logic       ballot_valid,
    output logic       busy,
    output logic [3:0] voted
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(VOTE_WINDOW);
    localparam logic [CW-1:0] DB_MAX     = CW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(VOTE_WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    ballot_q, ballot_d;
    logic [3:0]    voted_q, voted_d;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    db_prev_q, db_prev_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    db;
    logic [3:0]    new_vote;

    // Debounce path runs in every state so edges outside OPEN are consumed.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        db      = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!sync2_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != DB_MAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            db[i] = (cnt_q[i] == DB_MAX);
        end
        db_prev_d = db;
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        ballot_d = ballot_q;
        voted_d  = voted_q;
        new_vote = db & ~db_prev_q & ~voted_q;
        case (state_q)
            IDLE, HOLD: begin
                if (start) begin
                    state_d  = OPEN;
                    timer_d  = TIMER_LOAD;
                    ballot_d = '0;
                    voted_d  = '0;
                end
            end
            OPEN: begin
                // A vote landing on the closing edge still counts.
                ballot_d = ballot_q | new_vote;
                voted_d  = voted_q | new_vote;
                if (timer_q == '0 || voted_q == 4'b1111) begin
                    state_d = HOLD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            ballot_q  <= '0;
            voted_q   <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ballot_q  <= ballot_d;
            voted_q   <= voted_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_prev_q <= db_prev_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign ballot       = ballot_q;
    assign voted        = voted_q;
    assign busy         = (state_q == OPEN);
    assign ballot_valid = (state_q == HOLD);

endmodule

// File: tb/tb_vote_collector.sv
// Scoreboard bench for vote_collector: expected ballots and close cycles are queued by the
// stimulus and checked by a monitor whenever ballot_valid rises.
module tb_vote_collector;

    typedef struct {
        logic [3:0] ballot;
        int         close_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [3:0] ballot;
    logic       ballot_valid;
    logic       busy;
    logic [3:0] voted;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q [$];
    logic prev_valid = 1'b0;
    logic [3:0] held_ballot = 4'b0000;
    int   s;

    vote_collector #(.DEBOUNCE_CYCLES(4), .VOTE_WINDOW(64)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .btn(btn),
        .ballot(ballot),
        .ballot_valid(ballot_valid),
        .busy(busy),
        .voted(voted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop an expected ballot on every rising ballot_valid, and watch it stays frozen.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (ballot_valid === 1'b1 && prev_valid !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_close: ballot_valid rose at cycle %0d, ballot=%b, none expected", cyc, ballot);
            end else begin
                e = exp_q.pop_front();
                if (ballot !== e.ballot) begin
                    errors++;
                    $display("[TB] FAIL close_ballot: got %b expected %b at cycle %0d", ballot, e.ballot, cyc);
                end
                checks++;
                if (cyc != e.close_cyc) begin
                    errors++;
                    $display("[TB] FAIL close_cycle: closed at %0d expected %0d", cyc, e.close_cyc);
                end
            end
            held_ballot = ballot;
        end else if (ballot_valid === 1'b1) begin
            checks++;
            if (ballot !== held_ballot) begin
                errors++;
                $display("[TB] FAIL ballot_stable: got %b expected %b at cycle %0d", ballot, held_ballot, cyc);
            end
        end
        prev_valid = ballot_valid;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic applyStimulus(input logic s_in, input logic [3:0] b_in);
        start = s_in;
        btn   = b_in;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] e_ballot, input logic [3:0] e_voted,
                               input logic e_busy, input logic e_valid);
        checks++;
        if (ballot !== e_ballot || voted !== e_voted || busy !== e_busy || ballot_valid !== e_valid) begin
            errors++;
            $display("[TB] FAIL %s: got ballot=%b voted=%b busy=%b valid=%b expected ballot=%b voted=%b busy=%b valid=%b (cycle %0d)",
                     name, ballot, voted, busy, ballot_valid, e_ballot, e_voted, e_busy, e_valid, cyc);
        end
    endtask

    task automatic openSession();
        start = 1'b1;
        step(1);
        start = 1'b0;
        s = cyc;
    endtask

    initial begin
        // Reset
        applyStimulus(1'b0, 4'b0000);
        rst = 1'b1;
        step(2);
        checkOutput("reset_state", 4'b0000, 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        step(1);
        checkOutput("idle_after_reset", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Timed session with btn=0101 held 10 cycles
        openSession();
        checkOutput("open_entered", 4'b0000, 4'b0000, 1'b1, 1'b0);
        exp_q.push_back('{4'b0101, s + 64});
        applyStimulus(1'b0, 4'b0101);
        step(6);
        checkOutput("vote_latency_5", 4'b0000, 4'b0000, 1'b1, 1'b0);
        step(1);
        checkOutput("vote_latency_6", 4'b0101, 4'b0101, 1'b1, 1'b0);
        step(3);
        applyStimulus(1'b0, 4'b0000);
        waitUntil(s + 63);
        checkOutput("timeout_minus1", 4'b0101, 4'b0101, 1'b1, 1'b0);
        step(1);
        checkOutput("timeout_close", 4'b0101, 4'b0101, 1'b0, 1'b1);
        step(3);
        checkOutput("hold_frozen", 4'b0101, 4'b0101, 1'b0, 1'b1);

        // Start in HOLD, glitch rejection, start ignored mid-OPEN
        openSession();
        checkOutput("start_in_hold", 4'b0000, 4'b0000, 1'b1, 1'b0);
        exp_q.push_back('{4'b0000, s + 64});
        applyStimulus(1'b0, 4'b0010);
        step(3);
        applyStimulus(1'b0, 4'b0000);
        waitUntil(s + 20);
        checkOutput("glitch_rejected", 4'b0000, 4'b0000, 1'b1, 1'b0);
        waitUntil(s + 29);
        applyStimulus(1'b1, 4'b0000);
        step(1);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("start_ignored_open", 4'b0000, 4'b0000, 1'b1, 1'b0);
        waitUntil(s + 64);
        checkOutput("glitch_close", 4'b0000, 4'b0000, 1'b0, 1'b1);

        // Early close: presses staggered by 3 cycles, fourth vote at s+16
        openSession();
        exp_q.push_back('{4'b1111, s + 17});
        applyStimulus(1'b0, 4'b0001);
        step(3);
        applyStimulus(1'b0, 4'b0011);
        step(3);
        applyStimulus(1'b0, 4'b0111);
        step(3);
        applyStimulus(1'b0, 4'b1111);
        waitUntil(s + 15);
        checkOutput("early_three_votes", 4'b0111, 4'b0111, 1'b1, 1'b0);
        step(1);
        checkOutput("early_all_voted", 4'b1111, 4'b1111, 1'b1, 1'b0);
        step(1);
        checkOutput("early_close", 4'b1111, 4'b1111, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0000);

        // Held through start, then repress, then locked
        step(6);
        applyStimulus(1'b0, 4'b1000);
        step(8);
        openSession();
        exp_q.push_back('{4'b1000, s + 64});
        step(10);
        checkOutput("held_no_vote", 4'b0000, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000);
        step(6);
        applyStimulus(1'b0, 4'b1000);
        step(6);
        checkOutput("repress_pending", 4'b0000, 4'b0000, 1'b1, 1'b0);
        step(1);
        checkOutput("repress_vote", 4'b1000, 4'b1000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000);
        step(6);
        applyStimulus(1'b0, 4'b1000);
        step(8);
        checkOutput("third_press_locked", 4'b1000, 4'b1000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000);
        waitUntil(s + 64);
        checkOutput("lock_close", 4'b1000, 4'b1000, 1'b0, 1'b1);

        // Reset mid-session with two votes; rst beats a simultaneous start
        openSession();
        applyStimulus(1'b0, 4'b0011);
        waitUntil(s + 20);
        checkOutput("pre_reset_votes", 4'b0011, 4'b0011, 1'b1, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 4'b0000);
        step(1);
        checkOutput("reset_mid_open", 4'b0000, 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 4'b0000);
        step(4);
        checkOutput("idle_after_reset2", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Clean session after reset
        openSession();
        exp_q.push_back('{4'b0100, s + 64});
        applyStimulus(1'b0, 4'b0100);
        step(8);
        checkOutput("clean_vote", 4'b0100, 4'b0100, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000);
        waitUntil(s + 66);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_closes: %0d expected closes never seen, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
